// File: rtl/coriolis_sink_pkg.sv
// Shared encodings and the FloPoCo -> IEEE-754 single-precision conversion
// used by the stream sink.
package coriolis_sink_pkg;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } fpc_exc_e;

    localparam logic [31:0] IEEE_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  IEEE_EXP_MAX = 8'hFF;

    // Signed zero and infinity keep the FloPoCo sign; NaN is always the canonical quiet NaN.
    function automatic logic [31:0] fpc2ieee(input logic [33:0] w);
        logic [31:0] r;
        case (fpc_exc_e'(w[33:32]))
            EXC_ZERO:   r = {w[31], 31'b0};
            EXC_NORMAL: r = w[31:0];
            EXC_INF:    r = {w[31], IEEE_EXP_MAX, 23'b0};
            default:    r = IEEE_QNAN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coriolis_sink_fifo.sv
// Synchronous FIFO with occupancy level; head word is visible combinationally
// on rdata whenever the FIFO is non-empty.
module coriolis_sink_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

endmodule

// File: rtl/coriolis_stream_sink.sv
// Terminal sink for a FloPoCo map-node stream: converts to IEEE-754, buffers,
// and presents words on a first-word-fall-through output register.
module coriolis_stream_sink
    import coriolis_sink_pkg::*;
#(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 16,
    parameter int SLACK   = 4,
    parameter int NELEM   = 1024,
    parameter int CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in1_s0,
    output logic               iready,
    output logic               ovalid,
    output logic [31:0]        out1_s0,
    input  logic               oready,
    output logic [CNTW-1:0]    count,
    output logic               done,
    output logic               overflow
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   IREADY_MAX = LW'(DEPTH - SLACK);
    localparam logic [CNTW-1:0] NELEM_C    = CNTW'(NELEM);

    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          xfer;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;

    assign wdata = fpc2ieee(in1_s0);
    assign xfer  = ovalid & oready;
    // Pop requires a stored word, so a push into an empty FIFO is never bypassed.
    assign pop   = !empty && (!ovalid || oready);
    assign push  = ivalid && (!full || pop);
    assign level_next = level + LW'(push) - LW'(pop);

    coriolis_sink_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iready <= 1'b0;
        end else begin
            iready <= (level_next <= IREADY_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovalid  <= 1'b0;
            out1_s0 <= '0;
        end else if (pop) begin
            ovalid  <= 1'b1;
            out1_s0 <= rdata;
        end else if (oready) begin
            ovalid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (xfer && (count < NELEM_C)) begin
                count <= count + 1'b1;
                if (count == NELEM_C - 1'b1) begin
                    done <= 1'b1;
                end
            end
            if (ivalid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coriolis_stream_sink.sv
// Scoreboard bench for coriolis_stream_sink: stimulus queues expected IEEE
// words, a negedge monitor checks every delivered word plus count/done.
module tb_coriolis_stream_sink;

    localparam int NELEM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ivalid = 1'b0;
    logic [33:0] in1_s0 = '0;
    logic        oready = 1'b0;
    logic        iready;
    logic        ovalid;
    logic [31:0] out1_s0;
    logic [31:0] count;
    logic        done;
    logic        overflow;

    int          errors = 0;
    int          checks = 0;
    int          xfer_cnt = 0;
    int          accepted = 0;
    logic [31:0] exp_q [$];

    coriolis_stream_sink #(
        .STREAMW (34),
        .DEPTH   (16),
        .SLACK   (4),
        .NELEM   (NELEM),
        .CNTW    (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ivalid   (ivalid),
        .in1_s0   (in1_s0),
        .iready   (iready),
        .ovalid   (ovalid),
        .out1_s0  (out1_s0),
        .oready   (oready),
        .count    (count),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a transfer seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (!rst && ovalid && oready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", out1_s0);
            end else begin
                chk("out_word", out1_s0, exp_q.pop_front());
            end
            chk("count_at_xfer", count, 32'((xfer_cnt < NELEM) ? xfer_cnt : NELEM));
            chk("done_at_xfer", {31'b0, done}, 32'((xfer_cnt >= NELEM) ? 1 : 0));
            xfer_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [33:0] w, input logic [31:0] e, input bit keep);
        in1_s0 = w;
        ivalid = 1'b1;
        if (keep) exp_q.push_back(e);
        tick();
        ivalid = 1'b0;
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        ivalid = 1'b0;
        oready = 1'b0;
        #3;
        exp_q.delete();
        xfer_cnt = 0;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held
        #12;
        chk("rst_iready",   {31'b0, iready},   32'd0);
        chk("rst_ovalid",   {31'b0, ovalid},   32'd0);
        chk("rst_out",      out1_s0,           32'd0);
        chk("rst_count",    count,             32'd0);
        chk("rst_done",     {31'b0, done},     32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        #1 rst = 1'b0;
        tick();
        chk("iready_after_rst", {31'b0, iready}, 32'd1);

        // Normal word and two-cycle latency
        oready = 1'b1;
        send(34'h1_bd80ae10, 32'hbd80ae10, 1'b1);
        chk("lat_ovalid_n", {31'b0, ovalid}, 32'd0);
        tick();
        chk("lat_ovalid_n1", {31'b0, ovalid}, 32'd1);
        chk("lat_out", out1_s0, 32'hbd80ae10);
        tick();
        chk("normal_count", count, 32'd1);
        chk("normal_ovalid_low", {31'b0, ovalid}, 32'd0);

        // Exception encodings
        send(34'h0_80001234, 32'h80000000, 1'b1);
        send(34'h2_80000000, 32'hFF800000, 1'b1);
        send(34'h3_12345678, 32'h7FC00000, 1'b1);
        repeat (5) tick();
        chk("exc_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure with upstream obeying iready
        reset_dut();
        accepted = 0;
        repeat (30) begin
            if (iready) begin
                ivalid = 1'b1;
                in1_s0 = {2'b01, 32'hA000_0000 + 32'(accepted)};
                exp_q.push_back(32'hA000_0000 + 32'(accepted));
                accepted++;
            end else begin
                ivalid = 1'b0;
            end
            tick();
        end
        ivalid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'd14);
        chk("bp_iready_low", {31'b0, iready}, 32'd0);
        chk("bp_ovalid", {31'b0, ovalid}, 32'd1);
        chk("bp_no_overflow", {31'b0, overflow}, 32'd0);
        oready = 1'b1;
        repeat (20) tick();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_iready_back", {31'b0, iready}, 32'd1);
        chk("bp_overflow_end", {31'b0, overflow}, 32'd0);

        // Overflow: ignore iready, 18 words into a stalled sink
        reset_dut();
        for (int i = 1; i <= 18; i++) begin
            send({2'b01, 32'h4000_0000 + 32'(i)}, 32'h4000_0000 + 32'(i), i <= 17);
            if (i == 17) chk("ovf_before", {31'b0, overflow}, 32'd0);
        end
        chk("ovf_after", {31'b0, overflow}, 32'd1);
        oready = 1'b1;
        repeat (22) tick();
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Done after NELEM transfers, count saturates
        reset_dut();
        oready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send({2'b01, 32'h3F80_0000 + 32'(i)}, 32'h3F80_0000 + 32'(i), 1'b1);
        end
        repeat (6) tick();
        chk("done_count_sat", count, 32'd4);
        chk("done_flag", {31'b0, done}, 32'd1);
        chk("done_drained", 32'(exp_q.size()), 32'd0);
        chk("done_xfers", 32'(xfer_cnt), 32'd6);

        // Asynchronous reset mid-stream with buffered words
        reset_dut();
        oready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send({2'b01, 32'h1111_0000 + 32'(i)}, 32'h1111_0000 + 32'(i), 1'b1);
        end
        repeat (4) tick();
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send({2'b01, 32'h2222_0000 + 32'(i)}, 32'h2222_0000 + 32'(i), 1'b1);
        end
        chk("mid_pre_done", {31'b0, done}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_ovalid", {31'b0, ovalid}, 32'd0);
        chk("mid_iready", {31'b0, iready}, 32'd0);
        chk("mid_count",  count,           32'd0);
        chk("mid_done",   {31'b0, done},   32'd0);
        exp_q.delete();
        xfer_cnt = 0;
        #1 rst = 1'b0;
        tick();
        chk("mid_empty_after", {31'b0, ovalid}, 32'd0);
        oready = 1'b1;
        send(34'h1_c0490fdb, 32'hc0490fdb, 1'b1);
        repeat (3) tick();
        chk("mid_new_drained", 32'(exp_q.size()), 32'd0);
        chk("mid_new_count", count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
